// File: rtl/ovc_credit_tracker.sv
// Output-port VC allocator and credit counters for one router output port.
// Define OVC_ATOMIC_REALLOC_EN to hold an OVC in DRAINING until its downstream buffer is empty.
module ovc_credit_tracker #(
    parameter int                  NUM_VC      = 4,
    parameter int                  VC_ID_W     = 2,
    parameter int                  CREDIT_MAX  = 4,
    parameter int                  CREDIT_W    = 3,
    parameter int                  HEADER_LEN  = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b01,
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10,
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_req,
    output logic                       alloc_gnt,
    output logic [VC_ID_W-1:0]         alloc_vc,
    input  logic                       send_valid,
    input  logic [VC_ID_W-1:0]         send_vc,
    input  logic [HEADER_LEN-1:0]      send_type,
    input  logic                       credit_valid,
    input  logic [VC_ID_W-1:0]         credit_vc,
    output logic [NUM_VC*CREDIT_W-1:0] credit_cnt,
    output logic [NUM_VC-1:0]          ovc_busy,
    output logic                       err_underflow,
    output logic                       err_overflow,
    output logic                       err_proto
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } ovc_state_e;

`ifdef OVC_ATOMIC_REALLOC_EN
    localparam ovc_state_e END_STATE = ST_DRAIN;
`else
    localparam ovc_state_e END_STATE = ST_FREE;
`endif

    logic [VC_ID_W-1:0] ptr_q, ptr_d;
    logic [VC_ID_W-1:0] gnt_idx, cand;
    logic               gnt_found;
    logic [NUM_VC-1:0]  free_vec;
    logic [NUM_VC-1:0]  under_hit, over_hit, proto_hit;
    logic               is_end;
    logic               err_underflow_q, err_underflow_d;
    logic               err_overflow_q, err_overflow_d;
    logic               err_proto_q, err_proto_d;

    always_comb begin
        case (send_type)
            HEAD_FLIT, BODY_FLIT:   is_end = 1'b0;
            TAIL_FLIT, SINGLE_FLIT: is_end = 1'b1;
            default:                is_end = 1'b0;
        endcase
    end

    // Round-robin search for the first FREE OVC at or above the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NUM_VC; k++) begin
            cand = ptr_q + VC_ID_W'(k);
            if (!gnt_found && free_vec[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign alloc_gnt = alloc_req && gnt_found && !rst;
    assign alloc_vc  = gnt_idx;
    assign ptr_d     = alloc_gnt ? gnt_idx + VC_ID_W'(1) : ptr_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_ovc
            logic [CREDIT_W-1:0] cnt_q, cnt_d;
            ovc_state_e          st_q, st_d;
            logic                send_hit, cred_hit, grant_hit;
            logic                und, ovf, pro;

            assign send_hit  = send_valid   && (send_vc   == VC_ID_W'(gi));
            assign cred_hit  = credit_valid && (credit_vc == VC_ID_W'(gi));
            assign grant_hit = alloc_gnt    && (alloc_vc  == VC_ID_W'(gi));

            always_comb begin
                cnt_d = cnt_q;
                und   = 1'b0;
                ovf   = 1'b0;
                if (send_hit && !cred_hit) begin
                    if (cnt_q == '0) und = 1'b1;
                    else             cnt_d = cnt_q - CREDIT_W'(1);
                end else if (cred_hit && !send_hit) begin
                    if (cnt_q == CREDIT_W'(CREDIT_MAX)) ovf = 1'b1;
                    else                                cnt_d = cnt_q + CREDIT_W'(1);
                end
            end

            // A send in the same cycle as the grant belongs to the new packet.
            always_comb begin
                st_d = st_q;
                pro  = 1'b0;
                case (st_q)
                    ST_FREE: begin
                        if (grant_hit) begin
                            st_d = (send_hit && is_end) ? END_STATE : ST_BUSY;
                        end else if (send_hit) begin
                            pro = 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (send_hit && is_end) st_d = END_STATE;
                    end
                    ST_DRAIN: begin
                        if (cnt_d == CREDIT_W'(CREDIT_MAX)) st_d = ST_FREE;
                    end
                    default: st_d = ST_FREE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= CREDIT_W'(CREDIT_MAX);
                    st_q  <= ST_FREE;
                end else begin
                    cnt_q <= cnt_d;
                    st_q  <= st_d;
                end
            end

            assign credit_cnt[gi*CREDIT_W +: CREDIT_W] = cnt_q;
            assign ovc_busy[gi]  = (st_q != ST_FREE);
            assign free_vec[gi]  = (st_q == ST_FREE);
            assign under_hit[gi] = und;
            assign over_hit[gi]  = ovf;
            assign proto_hit[gi] = pro;
        end
    endgenerate

    assign err_underflow_d = err_underflow_q | (|under_hit);
    assign err_overflow_d  = err_overflow_q  | (|over_hit);
    assign err_proto_d     = err_proto_q     | (|proto_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q           <= '0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_proto_q     <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
            err_proto_q     <= err_proto_d;
        end
    end

    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign err_proto     = err_proto_q;

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Scoreboard bench for ovc_credit_tracker: directed stimulus queues expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_ovc_credit_tracker;

    localparam int NUM_VC = 4;
    localparam int VC_ID_W = 2;
    localparam int CREDIT_W = 3;
    localparam logic [1:0] HEAD   = 2'b01;
    localparam logic [1:0] BODY   = 2'b00;
    localparam logic [1:0] TAIL   = 2'b10;
    localparam logic [1:0] SINGLE = 2'b11;
`ifdef OVC_ATOMIC_REALLOC_EN
    localparam bit ATOMIC = 1'b1;
`else
    localparam bit ATOMIC = 1'b0;
`endif

    localparam int SEL_GNT  = 0;
    localparam int SEL_VC   = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_UND  = 3;
    localparam int SEL_OVF  = 4;
    localparam int SEL_PRO  = 5;
    localparam int SEL_CNT0 = 8;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       alloc_req;
    logic                       alloc_gnt;
    logic [VC_ID_W-1:0]         alloc_vc;
    logic                       send_valid;
    logic [VC_ID_W-1:0]         send_vc;
    logic [1:0]                 send_type;
    logic                       credit_valid;
    logic [VC_ID_W-1:0]         credit_vc;
    logic [NUM_VC*CREDIT_W-1:0] credit_cnt;
    logic [NUM_VC-1:0]          ovc_busy;
    logic                       err_underflow;
    logic                       err_overflow;
    logic                       err_proto;

    ovc_credit_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_vc     (alloc_vc),
        .send_valid   (send_valid),
        .send_vc      (send_vc),
        .send_type    (send_type),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_cnt   (credit_cnt),
        .ovc_busy     (ovc_busy),
        .err_underflow(err_underflow),
        .err_overflow (err_overflow),
        .err_proto    (err_proto)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int actual(input int sel);
        case (sel)
            SEL_GNT:  return int'(alloc_gnt);
            SEL_VC:   return int'(alloc_vc);
            SEL_BUSY: return int'(ovc_busy);
            SEL_UND:  return int'(err_underflow);
            SEL_OVF:  return int'(err_overflow);
            SEL_PRO:  return int'(err_proto);
            default:  return int'(credit_cnt[(sel-SEL_CNT0)*CREDIT_W +: CREDIT_W]);
        endcase
    endfunction

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   a;
            e = sb.pop_front();
            a = actual(e.sel);
            checks++;
            if (e.cyc != cyc || a != e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d got=%0d exp=%0d", e.name, cyc, e.cyc, a, e.exp);
            end
        end
    end

    task automatic expect_at(input int d, input int sel, input int e, input string n);
        exp_t x;
        x.cyc  = cyc + d;
        x.sel  = sel;
        x.exp  = e;
        x.name = n;
        sb.push_back(x);
    endtask

    task automatic exp_gnt(input bit g, input int vc);
        expect_at(0, SEL_GNT, int'(g), "alloc_gnt");
        if (g) expect_at(0, SEL_VC, vc, "alloc_vc");
    endtask

    task automatic set_in(input bit rq, input bit sv, input int svc, input logic [1:0] st,
                          input bit cv, input int cvc);
        alloc_req    = rq;
        send_valid   = sv;
        send_vc      = VC_ID_W'(svc);
        send_type    = st;
        credit_valid = cv;
        credit_vc    = VC_ID_W'(cvc);
    endtask

    task automatic tick();
        $display("cyc %0d rst=%0b req=%0b send=%0b vc=%0d type=%0d cred=%0b vc=%0d", cyc, rst,
                 alloc_req, send_valid, send_vc, send_type, credit_valid, credit_vc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1, 0, 0, BODY, 0, 0);
        expect_at(0, SEL_GNT, 0, "gnt_in_rst");
        for (int i = 0; i < NUM_VC; i++) expect_at(1, SEL_CNT0 + i, 4, "rst_cnt");
        expect_at(1, SEL_BUSY, 0, "rst_busy");
        expect_at(1, SEL_UND, 0, "rst_und");
        expect_at(1, SEL_OVF, 0, "rst_ovf");
        expect_at(1, SEL_PRO, 0, "rst_pro");
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, BODY, 0, 0);
        @(posedge clk);
        #1;

        // Round-robin allocation of all four OVCs, then exhaustion.
        do_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            set_in(1, 0, 0, BODY, 0, 0);
            exp_gnt(1, i);
            expect_at(1, SEL_BUSY, (1 << (i + 1)) - 1, "rr_busy");
            tick();
        end
        set_in(1, 0, 0, BODY, 0, 0);
        exp_gnt(0, 0);
        expect_at(1, SEL_BUSY, 15, "all_busy");
        tick();

        // Packet on OVC 2, then drain its credits back.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, BODY, 0, 0);
            exp_gnt(1, i);
            tick();
        end
        begin
            logic [1:0] pkt [4];
            pkt[0] = HEAD; pkt[1] = BODY; pkt[2] = BODY; pkt[3] = TAIL;
            for (int i = 0; i < 4; i++) begin
                set_in(0, 1, 2, pkt[i], 0, 0);
                expect_at(1, SEL_CNT0 + 2, 3 - i, "pkt_cnt2");
                expect_at(1, SEL_BUSY, (i == 3 && !ATOMIC) ? 3 : 7, "pkt_busy");
                tick();
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, BODY, 1, 2);
            expect_at(1, SEL_CNT0 + 2, i + 1, "drain_cnt2");
            expect_at(1, SEL_BUSY, (ATOMIC && i < 3) ? 7 : 3, "drain_busy");
            tick();
        end

        // Send and credit together on OVC 1.
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 1, BODY, 0, 0);
            expect_at(1, SEL_CNT0 + 1, 3 - i, "ovc1_cnt");
            tick();
        end
        set_in(0, 1, 1, BODY, 1, 1);
        expect_at(1, SEL_CNT0 + 1, 2, "same_cyc_cnt1");
        expect_at(1, SEL_UND, 0, "same_cyc_und");
        expect_at(1, SEL_OVF, 0, "same_cyc_ovf");
        tick();

        // Underflow on OVC 0.
        for (int i = 0; i < 5; i++) begin
            set_in(0, 1, 0, BODY, 0, 0);
            expect_at(1, SEL_CNT0, (i < 4) ? 3 - i : 0, "uf_cnt0");
            expect_at(1, SEL_UND, (i == 4) ? 1 : 0, "uf_flag");
            tick();
        end
        set_in(0, 0, 0, BODY, 0, 0);
        expect_at(1, SEL_CNT0, 0, "uf_hold_cnt0");
        expect_at(1, SEL_UND, 1, "uf_sticky");
        tick();

        // Overflow and protocol error on FREE OVC 3.
        set_in(0, 0, 0, BODY, 1, 3);
        expect_at(1, SEL_OVF, 1, "ovf_flag");
        expect_at(1, SEL_CNT0 + 3, 4, "ovf_cnt3");
        expect_at(1, SEL_PRO, 0, "pre_proto");
        tick();
        set_in(0, 1, 3, BODY, 0, 0);
        expect_at(1, SEL_PRO, 1, "proto_flag");
        expect_at(1, SEL_CNT0 + 3, 3, "proto_cnt3");
        expect_at(1, SEL_BUSY, 3, "proto_busy");
        tick();

        // Reallocation after a single-flit packet with credits outstanding.
        do_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            set_in(1, 0, 0, BODY, 0, 0);
            exp_gnt(1, i);
            tick();
        end
        set_in(1, 1, 0, SINGLE, 0, 0);
        exp_gnt(0, 0);
        expect_at(1, SEL_CNT0, 3, "single_cnt0");
        expect_at(1, SEL_BUSY, ATOMIC ? 15 : 14, "single_busy");
        tick();
        set_in(1, 0, 0, BODY, 0, 0);
        exp_gnt(!ATOMIC, 0);
        expect_at(1, SEL_BUSY, 15, "realloc_busy");
        tick();
        set_in(0, 0, 0, BODY, 1, 0);
        expect_at(1, SEL_CNT0, 4, "refill_cnt0");
        expect_at(1, SEL_BUSY, ATOMIC ? 14 : 15, "refill_busy");
        tick();

        // Sends in the grant cycle are legal.
        do_reset();
        set_in(1, 1, 0, HEAD, 0, 0);
        exp_gnt(1, 0);
        expect_at(1, SEL_CNT0, 3, "gc_cnt0");
        expect_at(1, SEL_BUSY, 1, "gc_busy0");
        expect_at(1, SEL_PRO, 0, "gc_proto0");
        tick();
        set_in(1, 1, 1, SINGLE, 0, 0);
        exp_gnt(1, 1);
        expect_at(1, SEL_CNT0 + 1, 3, "gc_cnt1");
        expect_at(1, SEL_BUSY, ATOMIC ? 3 : 1, "gc_busy1");
        expect_at(1, SEL_PRO, 0, "gc_proto1");
        tick();

        set_in(0, 0, 0, BODY, 0, 0);
        repeat (3) tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ovc_credit_tracker.md
Name: ovc_credit_tracker

Overview:
Upstream (transmitter) end of the router's credit-based flow control for one output port. Allocates output VCs to requesting input VCs. Keeps one credit counter per downstream VC buffer: each flit sent spends a credit, each credit returned by the downstream router refunds one. Drives the per-OVC credit counts that input VCs consume as their C input, and tracks each OVC's allocation state.

Parameters:
NUM_VC, 4, number of output VCs on this port (power of 2, >= 2)
VC_ID_W, 2, log2(NUM_VC)
CREDIT_MAX, 4, downstream VC buffer depth in flits; reset credit value
CREDIT_W, 3, counter width; must hold CREDIT_MAX
HEADER_LEN, 2, flit type field width
HEAD_FLIT, 2'b01, head type code
BODY_FLIT, 2'b00, body type code
TAIL_FLIT, 2'b10, tail type code
SINGLE_FLIT, 2'b11, single-flit packet type code

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req  in  1  an input VC requests a free OVC
alloc_gnt  out  1  grant, combinational, same cycle as alloc_req
alloc_vc  out  VC_ID_W  granted OVC index; valid only when alloc_gnt=1
send_valid  in  1  a flit leaves on the output link this cycle
send_vc  in  VC_ID_W  OVC carrying that flit
send_type  in  HEADER_LEN  type field of that flit
credit_valid  in  1  one credit returned from downstream
credit_vc  in  VC_ID_W  OVC the returned credit belongs to
credit_cnt  out  NUM_VC*CREDIT_W  packed per-OVC credit counts; OVC i occupies bits [i*CREDIT_W +: CREDIT_W]
ovc_busy  out  NUM_VC  1 = OVC not FREE
err_underflow  out  1  sticky: send_valid while the target OVC has 0 credits
err_overflow  out  1  sticky: credit returned to an OVC already at CREDIT_MAX with no send to it
err_proto  out  1  sticky: send_valid to an OVC in FREE state

Behaviour:
- Reset (clk edge with rst=1), values at the first edge:
  - all credit counts = CREDIT_MAX
  - all OVCs FREE; ovc_busy = 0
  - round-robin pointer = 0
  - all err_* = 0
  - alloc_gnt = 0 while rst is high
- Reset has priority over every input; it abandons in-flight allocations.
- Credit update per OVC i, next edge:
  - send to i only: count-1
  - credit to i only: count+1
  - both in the same cycle: unchanged, no error
- Underflow: send to an OVC at 0 (no credit for it) leaves the count at 0 and sets err_underflow.
- Overflow: credit to an OVC at CREDIT_MAX (no send to it) leaves the count saturated and sets err_overflow.
- Per-OVC state machine FREE / BUSY / DRAINING:
  - FREE -> BUSY when granted.
  - BUSY -> DRAINING when send_type is TAIL_FLIT or SINGLE_FLIT. A HEAD or BODY send stays BUSY.
  - DRAINING -> FREE on the cycle the post-update count equals CREDIT_MAX.
  - The DRAINING rule guarantees a new packet never shares a downstream buffer with an old one.
- Allocation:
  - alloc_gnt = alloc_req AND at least one OVC is FREE at the start of the cycle.
  - alloc_vc = first FREE OVC searching upward from the pointer, with wrap.
  - On a grant the pointer becomes alloc_vc+1 mod NUM_VC; with no grant it holds.
  - An OVC that becomes FREE at an edge is grantable from the following cycle only.
- Send in the grant cycle: a send to the OVC being granted that same cycle is legal. The state goes FREE -> BUSY, or FREE -> DRAINING for SINGLE_FLIT. The credit is spent; err_proto is not set.
- Send to any other FREE OVC sets err_proto. The credit is still spent; the state stays FREE.
- Error flags stay set until rst.
- Outputs: credit_cnt and ovc_busy are registered, so the effect of a send or credit appears one cycle later.

Optional Feature:
- Macro: OVC_ATOMIC_REALLOC_EN
- Defined: DRAINING state is used as described above.
- Undefined: a tail or single send moves BUSY -> FREE directly. The OVC is regrantable the next cycle while credits are still outstanding; the DRAINING encoding is unused.

Test Plan:
- Reset, then alloc_req=1 for 5 cycles with no sends -> grants on OVC 0,1,2,3 in successive cycles, no grant in cycle 5; ovc_busy=4'b1111.
- Grant OVC 2, then send HEAD, BODY, BODY, TAIL on OVC 2 over 4 cycles -> count 4,3,2,1,0 by cycle; state DRAINING. Return 4 credits -> FREE on the 4th credit's edge, count=4.
- Same cycle: send and credit both on OVC 1 at count 2 -> count stays 2, no error flags.
- 5 sends to OVC 0 with no credits returned -> count reaches 0, err_underflow=1 after the 5th; count stays 0.
- Credit to OVC 3 at count 4 -> err_overflow=1, count stays 4; send to FREE OVC 3 -> err_proto=1.
- With OVC_ATOMIC_REALLOC_EN undefined: SINGLE on OVC 0 at count 4 -> OVC 0 FREE and count 3 next cycle; alloc_req with pointer at 0 -> OVC 0 regranted.
